// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a single-request core interface into APB SETUP/ACCESS sequences.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | no transfer; PSEL low, request accepted here
//   SETUP  | PSEL high, PENABLE low for one cycle
//   ACCESS | PSEL and PENABLE high until PREADY (or timeout)
module apb_master_bridge #(
  parameter int BUS_WIDTH      = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [BUS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [BUS_WIDTH-1:0]  M_PADDR,
  output logic                  M_PWRITE,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, next_state;

  logic accept;
  logic complete;
  logic timeout;

  logic                  busy_d, done_d, err_d, psel_d, penable_d, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_d, pwdata_d;
  logic [BUS_WIDTH-1:0]  paddr_d;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  assign accept   = (state == IDLE) && req;
  assign complete = (state == ACCESS) && M_PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside ACCESS, so it is clear on every entry to ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!M_PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A PREADY in the expiring cycle wins: timeout requires PREADY low.
  assign timeout = (state == ACCESS) && !M_PREADY && (wait_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (complete || timeout) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs are computed from next_state so they line up with the state register.
  always_comb begin
    busy_d    = (next_state != IDLE);
    psel_d    = (next_state != IDLE);
    penable_d = (next_state == ACCESS);
    done_d    = complete || timeout;
    err_d     = timeout;
    paddr_d   = M_PADDR;
    pwrite_d  = M_PWRITE;
    pwdata_d  = M_PWDATA;
    rdata_d   = rdata;
    if (accept) begin
      paddr_d  = req_addr;
      pwrite_d = req_we;
      pwdata_d = req_wdata;
    end
    if (complete && !M_PWRITE) begin
      rdata_d = M_PRDATA;
    end else if (timeout) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PSELx   <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PWDATA  <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      rdata     <= rdata_d;
      M_PADDR   <= paddr_d;
      M_PWRITE  <= pwrite_d;
      M_PSELx   <= psel_d;
      M_PENABLE <= penable_d;
      M_PWDATA  <= pwdata_d;
    end
  end

endmodule
